// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
//  Module   : iterative_alu
//  Purpose  : Handshaked integer ALU. Base ALU ops (AND/OR/ADD/XOR, shifts,
//             SUB, SLT/SLTU) complete in one cycle. MUL/MULH/MULHSU/MULHU
//             and DIV/DIVU/REM/REMU run iteratively: one shift-add or one
//             restoring-division step per clock, then a sign-fix edge.
//  Ports    : iClock   - clock, rising edge
//             iReset   - synchronous active-high reset
//             iValid   - request valid
//             oReady   - request can be accepted this cycle
//             iControl - 5-bit operation code
//             iA, iB   - operands (captured at accept)
//             oValid   - oResult valid, held until iReady
//             iReady   - consumer takes the result this cycle
//             oResult  - registered result
//  Revision : 1.0 - initial release
// ============================================================================
module iterative_alu #(
  parameter int WIDTH = 32
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iValid,
  output logic             oReady,
  input  logic [4:0]       iControl,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oResult
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [1:0]           op;       // iControl[1:0] of the iterative op
  logic [2*WIDTH-1:0]   prod;     // MUL: {acc, multiplier}; DIV: {rem, quotient}
  logic [WIDTH-1:0]     opnd;     // multiplicand or divisor magnitude
  logic                 neg_q;    // negate product / quotient at the end
  logic                 neg_r;    // negate remainder at the end
  logic [WIDTH-1:0]     result;
  logic                 valid;

  logic                 accept;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     alu_res;

  logic                 is_iter;
  logic                 is_div;
  logic                 a_signed;
  logic                 b_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 div_zero;
  logic                 div_ovf;
  logic                 div_special;
  logic [WIDTH-1:0]     special_res;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   mul_full;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     fin;

  assign oReady  = !iReset && ((state == S_IDLE) || ((state == S_DONE) && iReady));
  assign accept  = iValid && oReady;
  assign oValid  = valid;
  assign oResult = result;
  assign shamt   = iB[SHAMT_W-1:0];

  // Single-cycle class
  always_comb begin
    alu_res = '0;
    case (iControl)
      5'b00000: alu_res = iA & iB;
      5'b00001: alu_res = iA | iB;
      5'b00010: alu_res = iA + iB;
      5'b00011: alu_res = iA ^ iB;
      5'b00100: alu_res = iA << shamt;
      5'b00101: alu_res = iA >> shamt;
      5'b01101: alu_res = $signed(iA) >>> shamt;
      5'b00110: alu_res = iA - iB;
      5'b00111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(iA) < $signed(iB))};
      5'b01111: alu_res = {{(WIDTH-1){1'b0}}, (iA < iB)};
      default:  alu_res = '0;
    endcase
  end

  // Operand preparation for the iterative class. Signed operands are reduced
  // to magnitudes; the most-negative value maps to 2^(WIDTH-1), which is the
  // correct unsigned magnitude.
  always_comb begin
    is_iter  = (iControl[4:3] == 2'b10);
    is_div   = iControl[2];
    a_signed = is_div ? !iControl[0] : ((iControl[1:0] == 2'b01) || (iControl[1:0] == 2'b10));
    b_signed = is_div ? !iControl[0] : (iControl[1:0] == 2'b01);
    a_neg    = a_signed && iA[WIDTH-1];
    b_neg    = b_signed && iB[WIDTH-1];
    a_mag    = a_neg ? (-iA) : iA;
    b_mag    = b_neg ? (-iB) : iB;
    div_zero = (iB == '0);
    div_ovf  = !iControl[0] && (iA == MIN_NEG) && (iB == '1);
    div_special = is_iter && is_div && (div_zero || div_ovf);
    if (div_zero) begin
      special_res = iControl[1] ? iA : '1;
    end else begin
      special_res = iControl[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration step of each engine
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, prod[WIDTH-1:1]};
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    // Borrow out of the trial subtraction means the divisor did not fit.
    if (div_diff[WIDTH]) begin
      div_next = {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction and half / quotient-remainder selection
  always_comb begin
    mul_full = neg_q ? (-prod) : prod;
    quo      = neg_q ? (-prod[WIDTH-1:0]) : prod[WIDTH-1:0];
    rem      = neg_r ? (-prod[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    if (state == S_MUL) begin
      fin = (op == 2'b00) ? mul_full[WIDTH-1:0] : mul_full[2*WIDTH-1:WIDTH];
    end else begin
      fin = op[1] ? rem : quo;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state  <= S_IDLE;
      count  <= '0;
      op     <= '0;
      prod   <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      valid  <= 1'b0;
    end else begin
      case (state)
        S_MUL, S_DIV: begin
          if (count != '0) begin
            prod  <= (state == S_MUL) ? mul_next : div_next;
            count <= count - CNT_ONE;
          end else begin
            result <= fin;
            valid  <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          // IDLE, or DONE where a take may coincide with a new accept
          if (accept) begin
            if (!is_iter) begin
              result <= alu_res;
              valid  <= 1'b1;
              state  <= S_DONE;
            end else if (div_special) begin
              result <= special_res;
              valid  <= 1'b1;
              state  <= S_DONE;
            end else begin
              op    <= iControl[1:0];
              prod  <= {{WIDTH{1'b0}}, a_mag};
              opnd  <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              count <= CNT_INIT;
              valid <= 1'b0;
              state <= is_div ? S_DIV : S_MUL;
            end
          end else if ((state == S_DONE) && iReady) begin
            valid <= 1'b0;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iterative_alu
//  Purpose  : Directed self-checking bench for iterative_alu at WIDTH=32 and
//             WIDTH=16 with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iterative_alu;

  logic        clk;
  logic        rst;

  logic        iv32, rdy32, ov32, ir32;
  logic [4:0]  ctrl32;
  logic [31:0] a32, b32, res32;

  logic        iv16, rdy16, ov16, ir16;
  logic [4:0]  ctrl16;
  logic [15:0] a16, b16, res16;

  int checks;
  int errors;

  iterative_alu #(.WIDTH(32)) dut32 (
    .iClock(clk), .iReset(rst), .iValid(iv32), .oReady(rdy32),
    .iControl(ctrl32), .iA(a32), .iB(b32), .oValid(ov32),
    .iReady(ir32), .oResult(res32)
  );

  iterative_alu #(.WIDTH(16)) dut16 (
    .iClock(clk), .iReset(rst), .iValid(iv16), .oReady(rdy16),
    .iControl(ctrl16), .iA(a16), .iB(b16), .oValid(ov16),
    .iReady(ir16), .oResult(res16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request, releases it after the accept edge (scrambling the
  // operands to prove they were captured), then counts the rising edges after
  // the accept edge until oValid is seen. Single-cycle ops give 0 edges.
  task automatic run32(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int edges, output logic [31:0] r);
    ctrl32 = c; a32 = a; b32 = b; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; a32 = ~a; b32 = ~b; ctrl32 = 5'b00000;
    edges = 0;
    while (!ov32 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    r = res32;
  endtask

  task automatic run16(input logic [4:0] c, input logic [15:0] a, input logic [15:0] b,
                       output int edges, output logic [15:0] r);
    ctrl16 = c; a16 = a; b16 = b; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = ~a; b16 = ~b; ctrl16 = 5'b00000;
    edges = 0;
    while (!ov16 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    r = res16;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ov32 !== 1'b0 || res32 !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: oValid=%b oResult=%h, required 0 and 00000000", ov32, res32);
    end
    checks++;
    if (rdy32 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: oReady=%b, required 0", rdy32);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy32 !== 1'b1 || rdy16 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: oReady32=%b oReady16=%b, required 1", rdy32, rdy16);
    end
  endtask

  task automatic test_single_cycle();
    logic [4:0]  c  [11] = '{5'b00010, 5'b00111, 5'b01111, 5'b01101, 5'b00110, 5'b00011,
                             5'b00100, 5'b00101, 5'b00000, 5'b00001, 5'b11000};
    logic [31:0] a  [11] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd5,
                             32'h12345678, 32'd1, 32'h80000000, 32'hF0F0F0F0,
                             32'hF0F0F0F0, 32'd5};
    logic [31:0] b  [11] = '{32'hFFFFFFFD, 32'd1, 32'd1, 32'd4, 32'd7, 32'hFFFF0000,
                             32'h25, 32'd4, 32'hFF00FF00, 32'hFF00FF00, 32'd7};
    logic [31:0] ex [11] = '{32'd4, 32'd1, 32'd0, 32'hF8000000, 32'hFFFFFFFE,
                             32'hEDCB5678, 32'h20, 32'h08000000, 32'hF000F000,
                             32'hFFF0FFF0, 32'h0};
    int e;
    logic [31:0] r;
    ir32 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run32(c[i], a[i], b[i], e, r);
      checks++;
      if (r !== ex[i] || e !== 0) begin
        errors++;
        $display("FAIL single_cycle op=%b: result=%h edges=%0d, required %h edges=0",
                 c[i], r, e, ex[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [4:0]  c  [5] = '{5'b10001, 5'b10000, 5'b10011, 5'b10010, 5'b10011};
    logic [31:0] a  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] b  [5] = '{32'd3, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3};
    logic [31:0] ex [5] = '{32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd2};
    int e;
    logic [31:0] r;
    ir32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run32(c[i], a[i], b[i], e, r);
      checks++;
      if (r !== ex[i] || e !== 33) begin
        errors++;
        $display("FAIL mul op=%b: result=%h edges=%0d, required %h edges=33",
                 c[i], r, e, ex[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [4:0]  c  [12] = '{5'b10100, 5'b10110, 5'b10101, 5'b10111, 5'b10100, 5'b10110,
                             5'b10101, 5'b10111, 5'b10100, 5'b10110, 5'b10101, 5'b10100};
    logic [31:0] a  [12] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000,
                             32'h80000000, 32'd100, 32'd100, 32'd7, 32'd7,
                             32'hFFFFFFFF, 32'h80000000};
    logic [31:0] b  [12] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd2, 32'd2};
    logic [31:0] ex [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000,
                             32'd0, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1,
                             32'h7FFFFFFF, 32'hC0000000};
    int          lat [12] = '{33, 33, 0, 0, 0, 0, 33, 33, 33, 33, 33, 33};
    int e;
    logic [31:0] r;
    ir32 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run32(c[i], a[i], b[i], e, r);
      checks++;
      if (r !== ex[i] || e !== lat[i]) begin
        errors++;
        $display("FAIL div op=%b a=%h b=%h: result=%h edges=%0d, required %h edges=%0d",
                 c[i], a[i], b[i], r, e, ex[i], lat[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  c  [3] = '{5'b00010, 5'b00110, 5'b00001};
    logic [31:0] a  [3] = '{32'd1, 32'd9, 32'd8};
    logic [31:0] b  [3] = '{32'd2, 32'd4, 32'd1};
    logic [31:0] ex [3] = '{32'd3, 32'd5, 32'd9};
    ir32 = 1'b1;
    iv32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ctrl32 = c[i]; a32 = a[i]; b32 = b[i];
      @(posedge clk); #1;
      checks++;
      if (ov32 !== 1'b1 || res32 !== ex[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: oValid=%b result=%h, required 1 and %h",
                 i, ov32, res32, ex[i]);
      end
    end
    iv32 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov32 !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_drain: oValid=%b, required 0", ov32);
    end
  endtask

  task automatic test_backpressure();
    int e;
    logic [31:0] r;
    ir32 = 1'b0;
    run32(5'b00010, 32'd10, 32'd20, e, r);
    checks++;
    if (r !== 32'd30 || e !== 0) begin
      errors++;
      $display("FAIL bp_first: result=%h edges=%0d, required 0000001e edges=0", r, e);
    end
    // A competing request must be ignored while the result is unclaimed.
    ctrl32 = 5'b00001; a32 = 32'hAAAA0000; b32 = 32'h00005555; iv32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ov32 !== 1'b1 || res32 !== 32'd30 || rdy32 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: oValid=%b result=%h oReady=%b, required 1 0000001e 0",
                 i, ov32, res32, rdy32);
      end
      @(posedge clk); #1;
    end
    ctrl32 = 5'b00011; a32 = 32'hFF; b32 = 32'h0F; ir32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    checks++;
    if (ov32 !== 1'b1 || res32 !== 32'hF0) begin
      errors++;
      $display("FAIL bp_release_xor: oValid=%b result=%h, required 1 000000f0", ov32, res32);
    end
    @(posedge clk); #1;
    checks++;
    if (ov32 !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: oValid=%b, required 0", ov32);
    end
  endtask

  task automatic test_reset_mid_op();
    int e;
    int stale;
    logic [31:0] r;
    ir32 = 1'b1;
    ctrl32 = 5'b10101; a32 = 32'd1000; b32 = 32'd3; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rdy32 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready: oReady=%b, required 0", rdy32);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ov32 !== 1'b0 || res32 !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs: oValid=%b result=%h, required 0 00000000", ov32, res32);
    end
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32 !== 1'b0) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL midreset_stale: oValid high for %0d cycles, required 0", stale);
    end
    run32(5'b00010, 32'd2, 32'd3, e, r);
    checks++;
    if (r !== 32'd5 || e !== 0) begin
      errors++;
      $display("FAIL midreset_add: result=%h edges=%0d, required 00000005 edges=0", r, e);
    end
  endtask

  task automatic test_width16();
    int e;
    logic [15:0] r;
    ir16 = 1'b1;
    run16(5'b10011, 16'hFFFF, 16'hFFFF, e, r);
    checks++;
    if (r !== 16'hFFFE || e !== 17) begin
      errors++;
      $display("FAIL w16_mulhu: result=%h edges=%0d, required fffe edges=17", r, e);
    end
    run16(5'b00100, 16'h0001, 16'h0013, e, r);
    checks++;
    if (r !== 16'h0008 || e !== 0) begin
      errors++;
      $display("FAIL w16_sll: result=%h edges=%0d, required 0008 edges=0", r, e);
    end
    run16(5'b10100, 16'hFFF9, 16'h0002, e, r);
    checks++;
    if (r !== 16'hFFFD || e !== 17) begin
      errors++;
      $display("FAIL w16_div: result=%h edges=%0d, required fffd edges=17", r, e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    iv32 = 1'b0; ir32 = 1'b0; ctrl32 = '0; a32 = '0; b32 = '0;
    iv16 = 1'b0; ir16 = 1'b0; ctrl16 = '0; a16 = '0; b16 = '0;
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Parametrised, handshaked successor to the single-cycle integer ALU.
- Covers the base RV32I ALU ops (plus XOR, shifts and SLTU) in one cycle, and the RV32M multiply/divide ops iteratively in WIDTH+1 cycles.
- Sits between the decode/operand-read stage and writeback; the core stalls on oReady/oValid.

Parameters:
- WIDTH, 32: operand and result width. Must be a power of two, ≥ 8.
- SHAMT_W, $clog2(WIDTH): derived localparam, not overridable. Width of the shift amount taken from iB.

Ports:
- iClock  in  1  clock; all state changes on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iValid  in  1  request valid.
- oReady  out  1  block can accept a request this cycle.
- iControl  in  5  operation code.
- iA  in  WIDTH  operand A.
- iB  in  WIDTH  operand B.
- oValid  out  1  oResult valid; held until taken.
- iReady  in  1  consumer takes the result this cycle.
- oResult  out  WIDTH  result, registered.

Behaviour:
- Opcodes, single-cycle class:
  - 00000 AND, 00001 OR, 00010 ADD, 00011 XOR.
  - 00100 SLL, 00101 SRL, 01101 SRA; shift amount is iB[SHAMT_W-1:0].
  - 00110 SUB, 00111 SLT (signed), 01111 SLTU.
  - SLT/SLTU produce 0 or 1, zero-extended.
- Opcodes, iterative class:
  - 10000 MUL (low WIDTH), 10001 MULH (s×s high), 10010 MULHSU (A signed × B unsigned, high), 10011 MULHU (high).
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- Any other code: result 0, single-cycle class.
- Accept = iValid && oReady at a rising edge. iA, iB and iControl are captured at accept and may change afterwards.
- States: IDLE, MUL, DIV, DONE.
  - oReady = (state==IDLE) || (state==DONE && iReady).
- Single-cycle class: at the accept edge, oResult is computed and written, and state goes to DONE. oValid is high from the next cycle (latency 1).
- Iterative class:
  - At accept, magnitudes of signed operands are loaded, the result sign is recorded, the count is set to WIDTH, and state goes to MUL or DIV.
  - Each edge performs one shift-add (MUL) or one restoring-division step (DIV) and decrements the count.
  - The edge after the count reaches 0 applies sign correction, selects the high/low half or quotient/remainder, writes oResult, and goes to DONE. oValid rises WIDTH+1 cycles after accept.
  - Remainder takes the sign of the dividend.
- Division special cases, resolved at the accept edge with latency 1 (straight to DONE):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (A = most-negative, B = −1): DIV gives the most-negative value; REM gives 0.
- DONE state:
  - oValid=1 and oResult stable while iReady=0.
  - iReady=1 with no new accept: go to IDLE, oValid=0 next cycle.
  - iReady=1 with a simultaneous accept: the new op is processed as from IDLE (back-to-back single-cycle ops give one result per cycle).
- iValid in MUL/DIV is ignored (oReady=0); the request is not queued.
- Reset, including mid-operation: state IDLE, oValid=0, oResult=0, count=0, internal operand/accumulator registers cleared. Any in-flight op is dropped with no result emitted. oReady=0 during the reset cycle; 1 in the first cycle after reset deasserts.
- All arithmetic is modulo 2^WIDTH; the product register is 2·WIDTH bits.

Test Plan:
- Reset, then ADD iA=7, iB=−3 with iReady held 1 → oValid one cycle after accept, oResult=4. Then SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0; SRA 0x80000000 by 4 → 0xF8000000.
- MULH iA=−2, iB=3 → oValid exactly 33 cycles after accept, oResult=0xFFFFFFFF. Then MUL → 0xFFFFFFFA. Then MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 7/0 → 0xFFFFFFFF at latency 1; DIV 0x80000000/−1 → 0x80000000; REM of the same → 0.
- Backpressure: iReady=0 for 5 cycles after oValid → oResult held, oReady=0, a new iValid is not accepted. Raise iReady together with iValid on an XOR → the XOR result appears the next cycle.
- Assert iReset 10 cycles into a DIVU → oValid=0 and oResult=0 after the reset edge, no stale result afterwards, and a fresh ADD completes correctly.
- Re-run a smoke subset at WIDTH=16: MULHU 0xFFFF×0xFFFF → 0xFFFE with latency 17; SLL by iB=0x13 uses a shift of 3.
